// File: rtl/sumador_serie_top.sv
// Bit-serial WIDTH-bit adder (LSB first, one full-adder cell + carry FF) with start/busy/done handshake.
// Latency WIDTH+1 cycles from accept to done; start ignored while busy. Optional SUMADOR_OVF_EN adds overflow_o.
module sumador_serie_top #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
`ifdef SUMADOR_OVF_EN
  output logic             overflow_o,
`endif
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             carry_next;
  logic             sum_bit;
  logic [CW-1:0]    cnt;

  // Single full-adder cell on the current LSBs.
  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign sum_next   = (sum_sh >> 1) | {sum_bit, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state == SHIFT);
  assign done_o = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
      carry_o  <= 1'b0;
`ifdef SUMADOR_OVF_EN
      overflow_o <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= data0_i;
      b_sh   <= data1_i;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_next;
      carry  <= carry_next;
      cnt    <= cnt + CW'(1);
      // Outputs take the post-edge values so they are valid throughout DONE.
      if (last_bit) begin
        result_o <= sum_next;
        carry_o  <= carry_next;
`ifdef SUMADOR_OVF_EN
        // carry here is the carry into the MSB; carry_next is the carry out.
        overflow_o <= carry ^ carry_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sumador_serie_top.sv
// Directed bench for sumador_serie_top (WIDTH=8): latency, handshake, reset abort, back-to-back starts.
module tb_sumador_serie_top;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] result;
  logic       carry;
  logic       busy;
  logic       done;
`ifdef SUMADOR_OVF_EN
  logic       overflow;
`endif

  int checks   = 0;
  int failures = 0;

  sumador_serie_top #(.WIDTH(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .data0_i  (data0),
    .data1_i  (data1),
    .result_o (result),
    .carry_o  (carry),
`ifdef SUMADOR_OVF_EN
    .overflow_o (overflow),
`endif
    .busy_o   (busy),
    .done_o   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Runs one operation; optionally disturbs start/data while busy.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_r, input logic exp_c, input logic exp_v,
                       input bit disturb);
    int nbusy;
    int lat;
    bit found;
    data0 = a;
    data1 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    lat   = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      if (busy) nbusy++;
      if (done) begin
        found = 1'b1;
        lat   = i;
        check_val({tag, "_result"}, 32'(result), 32'(exp_r));
        check_val({tag, "_carry"}, 32'(carry), 32'(exp_c));
`ifdef SUMADOR_OVF_EN
        check_val({tag, "_ovf"}, 32'(overflow), 32'(exp_v));
`endif
      end else begin
        if (disturb && i == 3) begin
          start = 1'b1;
          data0 = 8'd99;
          data1 = 8'd99;
        end
        if (disturb && i == 5) begin
          start = 1'b0;
          data0 = 8'd7;
          data1 = 8'd200;
        end
        @(negedge clk);
      end
    end
    check_val({tag, "_latency"}, 32'(lat), 32'd9);
    check_val({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    @(negedge clk);
    check_val({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  task automatic watch_no_done(input string tag, input int ncyc);
    int ndone;
    ndone = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_val(tag, 32'(ndone), 32'd0);
  endtask

  initial begin
    int d[$];
    int bad;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    data0 = '0;
    data1 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_carry", 32'(carry), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    @(negedge clk);

    do_op("a25_b17",   8'd25,  8'd17,  8'd42, 1'b0, 1'b0, 1'b0);
    do_op("a200_b100", 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1'b0);
    do_op("a255_b1",   8'd255, 8'd1,   8'd0,  1'b1, 1'b0, 1'b0);
    do_op("a0_b0",     8'd0,   8'd0,   8'd0,  1'b0, 1'b0, 1'b0);
`ifdef SUMADOR_OVF_EN
    do_op("ovf_100_100", 8'd100, 8'd100, 8'd200, 1'b0, 1'b1, 1'b0);
    do_op("ovf_128_128", 8'd128, 8'd128, 8'd0,   1'b1, 1'b1, 1'b0);
    do_op("ovf_255_1",   8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 1'b0);
`endif

    // Start pulse and data changes while busy must not affect the result.
    do_op("disturb_10_5", 8'd10, 8'd5, 8'd15, 1'b0, 1'b0, 1'b1);
    watch_no_done("disturb_no_extra_done", 15);

    // Reset on the 4th busy cycle abandons the operation.
    data0 = 8'd3;
    data1 = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_result", 32'(result), 32'd0);
    check_val("abort_carry", 32'(carry), 32'd0);
    watch_no_done("abort_no_done", 15);
    do_op("after_abort_1_2", 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0);

    // start held high: one accept per 10 cycles, result steady at 2.
    data0 = 8'd1;
    data1 = 8'd1;
    start = 1'b1;
    bad   = 0;
    seen  = 1'b0;
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
      if (done) begin
        d.push_back(i);
        seen = 1'b1;
      end
      if (seen && result !== 8'd2) bad++;
    end
    start = 1'b0;
    check_val("hold_num_done", 32'(d.size()), 32'd4);
    if (d.size() >= 3) begin
      check_val("hold_first_done", 32'(d[0]), 32'd9);
      check_val("hold_period1", 32'(d[1] - d[0]), 32'd10);
      check_val("hold_period2", 32'(d[2] - d[1]), 32'd10);
    end
    check_val("hold_result_steady", 32'(bad), 32'd0);
    check_val("hold_carry", 32'(carry), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sumador_serie_top.md
Name: sumador_serie_top

Overview:
- Bit-serial WIDTH-bit adder for the 8-bit ALU. It is the additive counterpart of the combinational subtractor and reuses the same operand/result naming.
- Adds data0_i + data1_i one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Uses a start/busy/done handshake so the ALU control FSM can run multi-cycle operations.
- Result and carry-out stay registered until the next accepted operation.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk_i  input  1  clock; all logic on its rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- start_i  input  1  request; accepted only in IDLE.
- data0_i  input  WIDTH  operand A (unsigned); sampled on the accept edge.
- data1_i  input  WIDTH  operand B (unsigned); sampled on the accept edge.
- result_o  output  WIDTH  registered sum A+B mod 2^WIDTH.
- carry_o  output  1  registered carry-out of the MSB.
- busy_o  output  1  high while bits are being processed.
- done_o  output  1  one-cycle pulse when result_o/carry_o update.

Behaviour:
- Reset (rst_ni=0 at a rising edge): state=IDLE; result_o=0, carry_o=0, busy_o=0, done_o=0; internal shift registers, carry FF and bit counter cleared. Reset has priority over all other inputs, including mid-operation. A computation in progress is abandoned and no done_o is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT when start_i=1 at an edge.
  - Latch A, B into shift registers.
  - Clear carry FF and sum shift register.
  - Counter=0.
- SHIFT:
  - Each edge: s = A[0]^B[0]^c; c' = majority(A[0],B[0],c).
  - A and B shift right by one.
  - s enters the MSB of the sum shift register, which shifts right.
  - Counter increments.
  - After the WIDTH-th SHIFT edge -> DONE. The sum register holds the full sum and the carry FF holds the carry-out.
- DONE (exactly one cycle): result_o<=sum register, carry_o<=carry FF at the edge entering DONE; done_o=1 during DONE. The next edge goes to IDLE.
- Timing: start accepted at edge k.
  - busy_o=1 in cycles k+1..k+WIDTH (WIDTH cycles).
  - done_o=1 in cycle k+WIDTH+1.
  - Total latency WIDTH+1 cycles; 9 cycles for WIDTH=8.
- busy_o is a registered, state-decoded output: high only in SHIFT. done_o is high only in DONE.
- start_i is ignored in SHIFT and DONE, and no request is queued. The earliest new accept is the first IDLE cycle, so back-to-back throughput is one operation per WIDTH+2 cycles.
- data0_i/data1_i changes after the accept edge have no effect on the running operation.
- result_o/carry_o hold the previous result throughout SHIFT. They change only on the edge entering DONE or on reset.
- Arithmetic: unsigned. result_o = (A+B) mod 2^WIDTH, carry_o = (A+B) >= 2^WIDTH.

Optional Feature:
- Macro SUMADOR_OVF_EN.
- Defined: adds output port overflow_o (1 bit).
  - Registered on the edge entering DONE, together with result_o.
  - overflow_o = carry into MSB XOR carry out of MSB (two's-complement signed overflow).
  - The design captures the carry FF value before the final SHIFT edge to derive it.
  - Reset value 0; held until the next DONE.
- Undefined: port and its logic absent; all other behaviour identical.

Test Plan:
- Reset, then start_i=1 with A=25, B=17 -> busy_o high 8 cycles; done_o pulse on 9th cycle after accept; result_o=42, carry_o=0.
- A=200, B=100 -> result_o=44, carry_o=1. Then A=255, B=1 -> result_o=0, carry_o=1. Then A=0, B=0 -> result_o=0, carry_o=0.
- Accept A=10, B=5; pulse start_i with A=99, B=99 during busy; change data inputs mid-run.
  - Exactly one done_o, result_o=15.
  - No second done_o without a new start_i in IDLE.
- Accept A=3, B=4; drive rst_ni=0 for one edge at the 4th busy cycle.
  - Next cycle: busy_o=0, done_o=0, result_o=0, carry_o=0.
  - No done_o afterwards.
  - A fresh start A=1, B=2 -> result_o=3.
- Hold start_i=1 continuously with A=1, B=1.
  - Accepts occur every 10 cycles.
  - result_o stays 2 between DONE cycles and does not glitch during SHIFT.
- With SUMADOR_OVF_EN:
  - A=100, B=100 -> result_o=200, carry_o=0, overflow_o=1.
  - A=128, B=128 -> result_o=0, carry_o=1, overflow_o=1.
  - A=255, B=1 -> overflow_o=0.
